note_track: RTL and testbench
=============================

// Module: note_track
// PURPOSE
//   Scrolling note lane for the rhythm game; sits directly upstream of button_judge.
//   Accepts chart notes (red/blue/rest) and shifts them toward the hit line at a fixed step rate.
//   Presents the nearest in-window note to the judge as node_R/node_B/offset.
//   Removes a note on delete_note; flags a miss when a note leaves unhit. Drives lane bitmaps to the LED matrix.
// PARAMETERS
//   LANE_LEN  16       number of lane cells; cell 0 is the hit-line end (>= WIN+1)
//   WIN       7        judge window, cells 0..WIN-1 (fixed 7: offset is 3 bits)
//   STEP_DIV  2500000  clk cycles per scroll step (>= 2)
// PORTS
//   clk           in   1         system clock
//   rst           in   1         synchronous reset, active-high
//   run           in   1         1 = scroll; 0 = freeze lane and step counter
//   chart_valid   in   1         chart note offered
//   chart_note    in   2         00 rest, 01 red, 10 blue, 11 illegal (treated as rest)
//   chart_ready   out  1         1-cycle pulse: chart note consumed this cycle
//   delete_note   in   1         from button_judge: clear current head note
//   node_R        out  1         head note is red
//   node_B        out  1         head note is blue
//   offset        out  3         head position: 0 none, 1 (cell 6, earliest) .. 7 (cell 0, latest)
//   lane_r        out  LANE_LEN  red occupancy bitmap, bit i = cell i
//   lane_b        out  LANE_LEN  blue occupancy bitmap
//   miss_pulse    out  1         1-cycle pulse: unhit note shifted out of cell 0
// BEHAVIOUR
//   - Reset: all cells empty, step counter 0; every output 0 (offset 0, no pulses).
//   - Step counter counts 0..STEP_DIV-1 while run=1; step_tick=1 when count==STEP_DIV-1, then wraps to 0.
//   - run=0: counter holds, no shift, chart_ready=0. delete_note is still honoured.
//   - chart_ready = step_tick. On step_tick: cell[i] <= cell[i+1]; cell[LANE_LEN-1] <= chart_valid ? chart_note : empty.
//     chart_valid without step_tick: note is not consumed; source holds it.
//   - Head = lowest-index non-empty cell in 0..WIN-1. offset = 7 - head_idx; node_R/node_B = head colour.
//     No head: offset=0, node_R=node_B=0. These outputs are combinational from the lane register (0-cycle latency).
//   - delete_note: head cell cleared at the next edge. delete_note with no head is ignored.
//   - delete_note and step_tick in the same cycle: clear first, then shift.
//     A deleted cell-0 note therefore raises no miss.
//   - miss_pulse = step_tick && cell[0] non-empty && !(delete_note && head_idx==0), registered, 1 cycle.
//   - lane_r/lane_b: registered mirror of cells, updated on the same edge as the shift/clear.
//   - Cells at index >= WIN are never reported as head; the judge cannot delete them.
//   - rst asserted mid-scroll: lane cleared at the next edge, no miss_pulse is generated, counter restarts.
// CONFIGURATION
//   NOTE_TRACK_MISS_CNT_EN defined:
//     - adds output miss_cnt[7:0].
//     - Increments on each miss_pulse, saturates at 255, cleared by rst.
//   Not defined: port and counter absent; all other behaviour identical.
// STRUCTURE
//   - Shared package note_pkg:
//     - NOTE_EMPTY=2'b00, NOTE_RED=2'b01, NOTE_BLUE=2'b10.
//     - OFFSET_NONE=3'd0, OFFSET_PERFECT=3'd3, WIN=7.
//     - Reused by button_judge and the chart ROM reader.
//   - One sub-module: step_timer (STEP_DIV divider with run enable, emits step_tick).
//   - Shift, head priority encoder and miss logic live in note_track.
// TESTING (STEP_DIV=4, LANE_LEN=16)
//   1 Reset: rst=1 two cycles mid-scroll with notes in lane -> lane_r=lane_b=0, offset=0, no miss_pulse.
//   2 Scroll: red offered once, run=1 -> chart_ready every 4 cycles; node_R=1, offset=1 at step 10;
//     offset=3 at step 12; offset=7 at step 16; miss_pulse at step 17.
//   3 Hit: blue note at offset=3, delete_note=1 one cycle -> cell cleared next edge, offset=0,
//     later miss_pulse never asserts.
//   4 Priority: red in cell 1 and blue in cell 4 -> node_R=1, offset=6. delete_note -> node_B=1, offset=3.
//   5 Simultaneous: note in cell 0, delete_note on step_tick cycle -> no miss_pulse, lane shifts normally.
//   6 Freeze/backpressure: run=0 for 10 cycles -> lane and counter hold, chart_ready=0;
//     chart_note=11 with valid -> inserted as empty.
//     With NOTE_TRACK_MISS_CNT_EN defined: 300 misses -> miss_cnt=255.

Source files
------------

// File: rtl/note_pkg.sv
// Shared note encodings and judge-window constants for note_track, button_judge and the chart ROM reader.
// Optional miss counter in note_track is enabled with NOTE_TRACK_MISS_CNT_EN.
package note_pkg;

    typedef enum logic [1:0] {
        NOTE_EMPTY   = 2'b00,
        NOTE_RED     = 2'b01,
        NOTE_BLUE    = 2'b10,
        NOTE_ILLEGAL = 2'b11
    } note_e;

    localparam logic [2:0] OFFSET_NONE    = 3'd0;
    localparam logic [2:0] OFFSET_PERFECT = 3'd3;
    localparam int         WIN            = 7;

    // Nearest note inside the judge window.
    typedef struct packed {
        logic       valid;
        logic [2:0] idx;
        note_e      colour;
    } head_t;

    // The illegal code is stored as a rest so the lane never holds it.
    function automatic note_e sanitize_note(input logic [1:0] raw);
        note_e n;
        case (raw)
            2'b01:   n = NOTE_RED;
            2'b10:   n = NOTE_BLUE;
            default: n = NOTE_EMPTY;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/note_track_step_timer.sv
// Scroll step divider: counts 0..STEP_DIV-1 while run is high and pulses step_tick_o on the last count.
// Holds its count while run is low; restarts from 0 on reset.
module step_timer #(
    parameter int unsigned STEP_DIV = 2500000
) (
    input  logic clk,
    input  logic rst,
    input  logic run_i,
    output logic step_tick_o
);

    localparam int unsigned     CNT_W   = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STEP_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // NOTE: default assigned first so every path drives cnt_d and no latch is inferred.
    always_comb begin
        cnt_d = cnt_q;
        if (run_i) begin
            cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
        end
    end

    // NOTE: non-blocking so all flops sample the pre-edge values together.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign step_tick_o = run_i && !rst && (cnt_q == CNT_MAX);

endmodule

// File: rtl/note_track.sv
// Scrolling note lane feeding button_judge: shifts chart notes toward the hit line and reports the head note.
// Define NOTE_TRACK_MISS_CNT_EN to add the saturating miss_cnt output.
module note_track
    import note_pkg::*;
#(
    parameter int unsigned LANE_LEN = 16,
    parameter int unsigned STEP_DIV = 2500000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                run,
    input  logic                chart_valid,
    input  logic [1:0]          chart_note,
    output logic                chart_ready,
    input  logic                delete_note,
    output logic                node_R,
    output logic                node_B,
    output logic [2:0]          offset,
    output logic [LANE_LEN-1:0] lane_r,
    output logic [LANE_LEN-1:0] lane_b,
    output logic                miss_pulse
`ifdef NOTE_TRACK_MISS_CNT_EN
    ,
    output logic [7:0]          miss_cnt
`endif
);

    logic step_tick;

    step_timer #(
        .STEP_DIV (STEP_DIV)
    ) u_step_timer (
        .clk         (clk),
        .rst         (rst),
        .run_i       (run),
        .step_tick_o (step_tick)
    );

    note_e               cells_q   [LANE_LEN];
    note_e               cells_clr [LANE_LEN];
    note_e               cells_d   [LANE_LEN];
    logic [LANE_LEN-1:0] lane_r_q, lane_r_d;
    logic [LANE_LEN-1:0] lane_b_q, lane_b_d;
    logic                miss_q, miss_d;
    head_t               head;

    // Priority encoder: scan downward so the lowest occupied window cell wins.
    always_comb begin
        head = '{valid: 1'b0, idx: 3'd0, colour: NOTE_EMPTY};
        for (int i = WIN - 1; i >= 0; i--) begin
            if (cells_q[i] != NOTE_EMPTY) begin
                head.valid  = 1'b1;
                head.idx    = 3'(i);
                head.colour = cells_q[i];
            end
        end
    end

    // Delete is applied before the shift, so a note hit in cell 0 never reaches the miss check.
    always_comb begin
        cells_clr = cells_q;
        if (delete_note && head.valid) begin
            cells_clr[head.idx] = NOTE_EMPTY;
        end

        miss_d = step_tick && (cells_clr[0] != NOTE_EMPTY);

        cells_d = cells_clr;
        if (step_tick) begin
            for (int i = 0; i < int'(LANE_LEN) - 1; i++) begin
                cells_d[i] = cells_clr[i + 1];
            end
            cells_d[LANE_LEN-1] = chart_valid ? sanitize_note(chart_note) : NOTE_EMPTY;
        end

        lane_r_d = '0;
        lane_b_d = '0;
        for (int i = 0; i < int'(LANE_LEN); i++) begin
            lane_r_d[i] = (cells_d[i] == NOTE_RED);
            lane_b_d[i] = (cells_d[i] == NOTE_BLUE);
        end
    end

    // NOTE: the lane is a handful of flops, not a RAM, so it is reset to guarantee an empty start.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(LANE_LEN); i++) begin
                cells_q[i] <= NOTE_EMPTY;
            end
            lane_r_q <= '0;
            lane_b_q <= '0;
            miss_q   <= 1'b0;
        end else begin
            cells_q  <= cells_d;
            lane_r_q <= lane_r_d;
            lane_b_q <= lane_b_d;
            miss_q   <= miss_d;
        end
    end

`ifdef NOTE_TRACK_MISS_CNT_EN
    logic [7:0] miss_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            miss_cnt_q <= 8'd0;
        end else if (miss_d && (miss_cnt_q != 8'hFF)) begin
            miss_cnt_q <= miss_cnt_q + 8'd1;
        end
    end

    assign miss_cnt = miss_cnt_q;
`endif

    assign chart_ready = step_tick;
    assign node_R      = head.valid && (head.colour == NOTE_RED);
    assign node_B      = head.valid && (head.colour == NOTE_BLUE);
    assign offset      = head.valid ? (3'd7 - head.idx) : OFFSET_NONE;
    assign lane_r      = lane_r_q;
    assign lane_b      = lane_b_q;
    assign miss_pulse  = miss_q;

endmodule

// File: tb/tb_note_track.sv
// Directed bench for note_track (STEP_DIV=4, LANE_LEN=16): table of per-step vectors plus hand sequences.
// Build with NOTE_TRACK_MISS_CNT_EN to also check the miss counter.
module tb_note_track;
    import note_pkg::*;

    localparam int LANE_LEN = 16;
    localparam int STEP_DIV = 4;

    logic                clk = 1'b0;
    logic                rst, run, chart_valid, delete_note;
    logic [1:0]          chart_note;
    logic                chart_ready, node_R, node_B, miss_pulse;
    logic [2:0]          offset;
    logic [LANE_LEN-1:0] lane_r, lane_b;
`ifdef NOTE_TRACK_MISS_CNT_EN
    logic [7:0]          miss_cnt;
`endif

    note_track #(.LANE_LEN(LANE_LEN), .STEP_DIV(STEP_DIV)) dut (
        .clk         (clk),
        .rst         (rst),
        .run         (run),
        .chart_valid (chart_valid),
        .chart_note  (chart_note),
        .chart_ready (chart_ready),
        .delete_note (delete_note),
        .node_R      (node_R),
        .node_B      (node_B),
        .offset      (offset),
        .lane_r      (lane_r),
        .lane_b      (lane_b),
        .miss_pulse  (miss_pulse)
`ifdef NOTE_TRACK_MISS_CNT_EN
        ,
        .miss_cnt    (miss_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic check_state(input string tag, input logic [15:0] r, input logic [15:0] b,
                               input logic [2:0] off, input logic nr, input logic nb, input logic miss);
        check({tag, "_lane_r"}, 32'(lane_r), 32'(r));
        check({tag, "_lane_b"}, 32'(lane_b), 32'(b));
        check({tag, "_offset"}, 32'(offset), 32'(off));
        check({tag, "_node_R"}, 32'(node_R), 32'(nr));
        check({tag, "_node_B"}, 32'(node_B), 32'(nb));
        check({tag, "_miss"},   32'(miss_pulse), 32'(miss));
    endtask

    // Called at posedge+1; waits for chart_ready, applies del in that cycle, returns at posedge+1 after the shift.
    task automatic do_step(input logic v, input logic [1:0] n, input logic d,
                           input int exp_cycles, input string tag);
        int cycles;
        bit seen;
        cycles = 0;
        seen   = 0;
        chart_valid = v;
        chart_note  = n;
        delete_note = 1'b0;
        while (!seen && cycles < 4 * STEP_DIV) begin
            cycles++;
            #1;
            if (chart_ready === 1'b1) begin
                seen = 1;
                delete_note = d;
            end
            @(posedge clk);
            #1;
        end
        chart_valid = 1'b0;
        chart_note  = 2'b00;
        delete_note = 1'b0;
        if (!seen) begin
            check({tag, "_timeout"}, 32'd0, 32'd1);
        end else if (exp_cycles != 0) begin
            check({tag, "_period"}, 32'(cycles), 32'(exp_cycles));
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        int          n;
        logic        v;
        logic [1:0]  note;
        logic        del;
        logic [15:0] r;
        logic [15:0] b;
        logic [2:0]  off;
        logic        nr;
        logic        nb;
        logic        miss;
    } vec_t;

    function automatic vec_t mk(input int n, input logic v, input logic [1:0] note, input logic del,
                                input logic [15:0] r, input logic [15:0] b, input logic [2:0] off,
                                input logic nr, input logic nb, input logic miss);
        vec_t x;
        x.n = n; x.v = v; x.note = note; x.del = del; x.r = r; x.b = b;
        x.off = off; x.nr = nr; x.nb = nb; x.miss = miss;
        return x;
    endfunction

    vec_t vecs[14];

    initial begin
        bit aligned;

        // n steps per row: n-1 idle steps, then one step with the row's inputs, then compare.
        vecs[0]  = mk(1,  1, 2'b01, 0, 16'h8000, 16'h0000, 3'd0, 0, 0, 0);
        vecs[1]  = mk(8,  0, 2'b00, 0, 16'h0080, 16'h0000, 3'd0, 0, 0, 0);
        vecs[2]  = mk(1,  0, 2'b00, 0, 16'h0040, 16'h0000, 3'd1, 1, 0, 0);
        vecs[3]  = mk(2,  0, 2'b00, 0, 16'h0010, 16'h0000, 3'd3, 1, 0, 0);
        vecs[4]  = mk(4,  0, 2'b00, 0, 16'h0001, 16'h0000, 3'd7, 1, 0, 0);
        vecs[5]  = mk(1,  0, 2'b00, 0, 16'h0000, 16'h0000, 3'd0, 0, 0, 1);
        vecs[6]  = mk(1,  1, 2'b10, 0, 16'h0000, 16'h8000, 3'd0, 0, 0, 0);
        vecs[7]  = mk(1,  1, 2'b01, 0, 16'h8000, 16'h4000, 3'd0, 0, 0, 0);
        vecs[8]  = mk(14, 0, 2'b00, 0, 16'h0002, 16'h0001, 3'd7, 0, 1, 0);
        vecs[9]  = mk(1,  0, 2'b00, 1, 16'h0001, 16'h0000, 3'd7, 1, 0, 0);
        vecs[10] = mk(1,  0, 2'b00, 0, 16'h0000, 16'h0000, 3'd0, 0, 0, 1);
        vecs[11] = mk(1,  1, 2'b11, 0, 16'h0000, 16'h0000, 3'd0, 0, 0, 0);
        vecs[12] = mk(15, 0, 2'b00, 0, 16'h0000, 16'h0000, 3'd0, 0, 0, 0);
        vecs[13] = mk(1,  0, 2'b00, 0, 16'h0000, 16'h0000, 3'd0, 0, 0, 0);

        rst = 1'b1; run = 1'b0; chart_valid = 1'b0; chart_note = 2'b00; delete_note = 1'b0;
        cycle();
        cycle();
        check_state("reset", 16'h0, 16'h0, 3'd0, 0, 0, 0);
        check("reset_ready", 32'(chart_ready), 32'd0);
        rst = 1'b0;
        run = 1'b1;

        aligned = 1;
        for (int i = 0; i < 14; i++) begin
            for (int k = 0; k < vecs[i].n - 1; k++) begin
                do_step(1'b0, 2'b00, 1'b0, aligned ? STEP_DIV : 0, $sformatf("v%0d_idle", i));
                aligned = 1;
            end
            do_step(vecs[i].v, vecs[i].note, vecs[i].del, aligned ? STEP_DIV : 0, $sformatf("v%0d", i));
            aligned = 1;
            check_state($sformatf("v%0d", i), vecs[i].r, vecs[i].b, vecs[i].off,
                        vecs[i].nr, vecs[i].nb, vecs[i].miss);
            if (vecs[i].miss) begin
                cycle();
                check($sformatf("v%0d_miss_width", i), 32'(miss_pulse), 32'd0);
                aligned = 0;
            end
        end
`ifdef NOTE_TRACK_MISS_CNT_EN
        check("miss_cnt", 32'(miss_cnt), 32'd2);
`endif

        // Priority: red in cell 1, blue in cell 4, then two mid-period deletes.
        do_step(1'b1, 2'b01, 1'b0, STEP_DIV, "prio_red");
        do_step(1'b0, 2'b00, 1'b0, STEP_DIV, "prio_gap");
        do_step(1'b0, 2'b00, 1'b0, STEP_DIV, "prio_gap");
        do_step(1'b1, 2'b10, 1'b0, STEP_DIV, "prio_blue");
        for (int k = 0; k < 11; k++) do_step(1'b0, 2'b00, 1'b0, STEP_DIV, "prio_run");
        check_state("prio", 16'h0002, 16'h0010, 3'd6, 1, 0, 0);
        delete_note = 1'b1;
        cycle();
        delete_note = 1'b0;
        check_state("prio_del1", 16'h0000, 16'h0010, 3'd3, 0, 1, 0);
        delete_note = 1'b1;
        cycle();
        delete_note = 1'b0;
        check_state("hit_del2", 16'h0000, 16'h0000, 3'd0, 0, 0, 0);
        do_step(1'b0, 2'b00, 1'b0, 2, "hit_resume");
        check("hit_miss0", 32'(miss_pulse), 32'd0);
        for (int k = 0; k < 5; k++) begin
            do_step(1'b0, 2'b00, 1'b0, STEP_DIV, "hit_run");
            check($sformatf("hit_miss%0d", k + 1), 32'(miss_pulse), 32'd0);
        end

        // Freeze with a held blue offer, then a delete while frozen.
        do_step(1'b1, 2'b01, 1'b0, STEP_DIV, "frz_red");
        for (int k = 0; k < 9; k++) do_step(1'b0, 2'b00, 1'b0, STEP_DIV, "frz_run");
        check_state("frz_pre", 16'h0040, 16'h0000, 3'd1, 1, 0, 0);
        cycle();
        cycle();
        run = 1'b0;
        chart_valid = 1'b1;
        chart_note  = 2'b10;
        for (int k = 0; k < 10; k++) begin
            #1;
            check($sformatf("frz_ready%0d", k), 32'(chart_ready), 32'd0);
            cycle();
        end
        check_state("frz_hold", 16'h0040, 16'h0000, 3'd1, 1, 0, 0);
        chart_valid = 1'b0;
        delete_note = 1'b1;
        cycle();
        delete_note = 1'b0;
        check_state("frz_del", 16'h0000, 16'h0000, 3'd0, 0, 0, 0);
        run = 1'b1;
        do_step(1'b0, 2'b00, 1'b0, 2, "frz_resume");
        check_state("frz_after", 16'h0000, 16'h0000, 3'd0, 0, 0, 0);

        // Reset mid-scroll with a red note in cell 0 and blue in cell 1.
        do_step(1'b1, 2'b01, 1'b0, STEP_DIV, "rst_red");
        do_step(1'b1, 2'b10, 1'b0, STEP_DIV, "rst_blue");
        for (int k = 0; k < 14; k++) do_step(1'b0, 2'b00, 1'b0, STEP_DIV, "rst_run");
        check_state("rst_pre", 16'h0001, 16'h0002, 3'd7, 1, 0, 0);
        cycle();
        cycle();
        rst = 1'b1;
        cycle();
        check_state("rst_c1", 16'h0000, 16'h0000, 3'd0, 0, 0, 0);
        #1;
        check("rst_ready", 32'(chart_ready), 32'd0);
        cycle();
        check_state("rst_c2", 16'h0000, 16'h0000, 3'd0, 0, 0, 0);
        rst = 1'b0;
        do_step(1'b0, 2'b00, 1'b0, STEP_DIV, "rst_restart");
        check_state("rst_after", 16'h0000, 16'h0000, 3'd0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
